// File: rtl/parking_gate_controller_if.sv
// Gate-side handshake and event bundle of the parking gate controller.
// The master side is the gate sensors / smart_parking consumer, the slave
// side is the controller itself.
interface parking_gate_controller_if;
  logic       entry_req;
  logic       exit_req;
  logic [2:0] exit_slot;
  logic       entry_ready;
  logic       exit_ready;
  logic       entry;
  logic       exit;
  logic [2:0] pattern;
  logic [7:0] parking_capacity;
  logic [7:0] time_in;
  logic [7:0] time_out;
  logic       ev_valid;
  logic       err;

  modport master (
    output entry_req, exit_req, exit_slot,
    input  entry_ready, exit_ready, entry, exit, pattern, parking_capacity,
           time_in, time_out, ev_valid, err
  );

  modport slave (
    input  entry_req, exit_req, exit_slot,
    output entry_ready, exit_ready, entry, exit, pattern, parking_capacity,
           time_in, time_out, ev_valid, err
  );
endinterface

// File: rtl/parking_gate_controller.sv
// Parking gate controller: owns the 8-slot occupancy bitmap (1 = free), a
// prescaled wrapping 8-bit parking clock and per-slot entry timestamps.
// Each accepted entry/exit request is presented as one single-cycle event.
module parking_gate_controller #(
  parameter int TICK_DIV = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  parking_gate_controller_if.slave        gate,
  output logic [3:0]                      occupied,
  output logic                            full
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;
  localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);

  logic [0:0] state;
  logic [7:0] map;
  logic [7:0] now;
  logic [7:0] presc;
  logic [7:0] ts [8];
  logic [2:0] pattern_q;
  logic [7:0] time_in_q;
  logic [7:0] time_out_q;
  logic       is_entry;
  logic       is_exit;
  logic       is_err;
  logic [2:0] free_slot;
  logic       idle;
  logic       entry_acc;
  logic       exit_acc;

  function automatic logic [3:0] count_free(input logic [7:0] m);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, m[i]};
    return n;
  endfunction

  assign occupied = 4'd8 - count_free(map);
  assign full     = (map == 8'h00);

  assign idle             = (state == IDLE);
  assign gate.exit_ready  = idle & ~rst;
  assign gate.entry_ready = idle & ~rst & ~full & ~gate.exit_req;
  assign exit_acc         = gate.exit_req & gate.exit_ready;
  assign entry_acc        = gate.entry_req & gate.entry_ready;

  // Event outputs are only live in PRESENT; the map is still pre-event there
  assign gate.entry            = ~idle & is_entry;
  assign gate.exit             = ~idle & is_exit;
  assign gate.ev_valid         = ~idle & (is_entry | is_exit);
  assign gate.err              = ~idle & is_err;
  assign gate.pattern          = pattern_q;
  assign gate.time_in          = time_in_q;
  assign gate.time_out         = time_out_q;
  assign gate.parking_capacity = map;

  // Lowest-index free slot for entry allocation
  always_comb begin
    free_slot = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (map[i]) free_slot = 3'(i);
    end
  end

  // Parking clock: prescale tick pulses, advance now on the TICK_DIV-th one
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= 8'd0;
      now   <= 8'd0;
    end else if (tick) begin
      if (presc == DIV_LAST) begin
        presc <= 8'd0;
        now   <= now + 8'd1;
      end else begin
        presc <= presc + 8'd1;
      end
    end
  end

  // Accept requests in IDLE, commit map/timestamp at the end of PRESENT
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      map        <= 8'hFF;
      pattern_q  <= 3'd0;
      time_in_q  <= 8'd0;
      time_out_q <= 8'd0;
      is_entry   <= 1'b0;
      is_exit    <= 1'b0;
      is_err     <= 1'b0;
      for (int i = 0; i < 8; i++) ts[i] <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (exit_acc) begin
            pattern_q  <= gate.exit_slot;
            time_in_q  <= ts[gate.exit_slot];
            time_out_q <= now;
            is_entry   <= 1'b0;
            is_exit    <= ~map[gate.exit_slot];
            is_err     <= map[gate.exit_slot];
            state      <= PRESENT;
          end else if (entry_acc) begin
            pattern_q  <= free_slot;
            time_in_q  <= now;
            time_out_q <= now;
            is_entry   <= 1'b1;
            is_exit    <= 1'b0;
            is_err     <= 1'b0;
            state      <= PRESENT;
          end
        end
        default: begin
          if (is_entry) begin
            map[pattern_q] <= 1'b0;
            ts[pattern_q]  <= time_in_q;
          end
          if (is_exit) map[pattern_q] <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench for parking_gate_controller: the driver pushes the
// expected event for every accepted request, the monitor pops and compares
// whenever the controller presents an event or an error.
module tb_parking_gate_controller;
  localparam int TDIV = 3;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [3:0] occupied;
  logic       full;

  parking_gate_controller_if ifc ();

  parking_gate_controller #(.TICK_DIV(TDIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .gate     (ifc.slave),
    .occupied (occupied),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_entry;
    bit         is_exit;
    bit         is_err;
    logic [2:0] pat;
    logic [7:0] tin;
    logic [7:0] tout;
    logic [7:0] cap;
  } ev_t;

  ev_t        q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         tick_seen = 0;
  bit         tick_rand = 1'b0;
  bit         mfree [8];
  logic [7:0] mts [8];

  // Reference time base: number of ticks seen since reset
  always @(posedge clk) begin
    if (rst) tick_seen <= 0;
    else if (tick) tick_seen <= tick_seen + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mnow();
    return 8'((tick_seen / TDIV) % 256);
  endfunction

  function automatic logic [7:0] mcap();
    logic [7:0] c;
    for (int i = 0; i < 8; i++) c[i] = mfree[i];
    return c;
  endfunction

  function automatic int mfree_cnt();
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (mfree[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mfree[i] = 1'b1;
      mts[i]   = 8'd0;
    end
  endtask

  task automatic acc_entry();
    ev_t e;
    int  s;
    s = -1;
    for (int i = 7; i >= 0; i--) if (mfree[i]) s = i;
    e.is_entry = 1'b1; e.is_exit = 1'b0; e.is_err = 1'b0;
    e.pat = 3'(s); e.tin = mnow(); e.tout = mnow(); e.cap = mcap();
    q.push_back(e);
    if (s >= 0) begin
      mfree[s] = 1'b0;
      mts[s]   = mnow();
    end
  endtask

  task automatic acc_exit(input logic [2:0] slot);
    ev_t e;
    e.is_entry = 1'b0;
    e.is_exit  = !mfree[slot];
    e.is_err   = mfree[slot];
    e.pat = slot; e.tin = mts[slot]; e.tout = mnow(); e.cap = mcap();
    q.push_back(e);
    mfree[slot] = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    tick = tick_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic pulse_ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  task automatic do_entry();
    ifc.entry_req = 1'b1;
    #1;
    for (int i = 0; i < 60; i++) begin
      if (ifc.entry_ready === 1'b1) begin
        acc_entry();
        step();
        ifc.entry_req = 1'b0;
        return;
      end
      step();
    end
    chk("entry_accept_timeout", 32'(ifc.entry_ready), 32'd1);
    ifc.entry_req = 1'b0;
  endtask

  task automatic do_exit(input logic [2:0] slot);
    ifc.exit_req  = 1'b1;
    ifc.exit_slot = slot;
    #1;
    for (int i = 0; i < 60; i++) begin
      if (ifc.exit_ready === 1'b1) begin
        acc_exit(slot);
        step();
        ifc.exit_req = 1'b0;
        return;
      end
      step();
    end
    chk("exit_accept_timeout", 32'(ifc.exit_ready), 32'd1);
    ifc.exit_req = 1'b0;
  endtask

  task automatic do_both(input logic [2:0] slot);
    ifc.entry_req = 1'b1;
    do_exit(slot);
    do_entry();
  endtask

  task automatic check_idle();
    step();
    chk("capacity", 32'(ifc.parking_capacity), 32'(mcap()));
    chk("occupied", 32'(occupied), 32'(8 - mfree_cnt()));
    chk("full", 32'(full), 32'(mfree_cnt() == 0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every presented event or error must match the oldest expectation
  always @(negedge clk) begin
    if (ifc.ev_valid === 1'b1 || ifc.err === 1'b1 || ifc.entry === 1'b1 || ifc.exit === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_event", 32'(ifc.ev_valid), 32'd0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_entry", 32'(ifc.entry), 32'(e.is_entry));
        chk("ev_exit", 32'(ifc.exit), 32'(e.is_exit));
        chk("ev_err", 32'(ifc.err), 32'(e.is_err));
        chk("ev_valid", 32'(ifc.ev_valid), 32'(e.is_entry | e.is_exit));
        chk("ev_pattern", 32'(ifc.pattern), 32'(e.pat));
        chk("ev_time_in", 32'(ifc.time_in), 32'(e.tin));
        chk("ev_time_out", 32'(ifc.time_out), 32'(e.tout));
        chk("ev_capacity", 32'(ifc.parking_capacity), 32'(e.cap));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.entry_req = 1'b0;
    ifc.exit_req  = 1'b0;
    ifc.exit_slot = 3'd0;
    tick = 1'b0;
    rst  = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    // Reset values while rst is still high
    chk("rst_entry_ready", 32'(ifc.entry_ready), 32'd0);
    chk("rst_exit_ready", 32'(ifc.exit_ready), 32'd0);
    chk("rst_capacity", 32'(ifc.parking_capacity), 32'hFF);
    chk("rst_occupied", 32'(occupied), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ev_valid", 32'(ifc.ev_valid), 32'd0);
    chk("rst_err", 32'(ifc.err), 32'd0);
    chk("rst_pattern", 32'(ifc.pattern), 32'd0);
    chk("rst_time_in", 32'(ifc.time_in), 32'd0);
    chk("rst_time_out", 32'(ifc.time_out), 32'd0);
    rst = 1'b0;

    // Three entries at now = 0, 0, 5
    do_entry();
    do_entry();
    pulse_ticks(5 * TDIV);
    do_entry();
    check_idle();

    // Exit slot 1 once now reaches 0x2A
    pulse_ticks((8'h2A - 5) * TDIV);
    do_exit(3'd1);
    check_idle();

    // Simultaneous entry and exit of slot 0: exit first, entry reuses slot 0
    do_both(3'd0);
    check_idle();

    // Fill the lot, hold an entry, free slot 5 under the held entry
    while (mfree_cnt() > 0) do_entry();
    check_idle();
    ifc.entry_req = 1'b1;
    #1;
    repeat (3) begin
      chk("full_entry_ready", 32'(ifc.entry_ready), 32'd0);
      step();
    end
    do_both(3'd5);
    check_idle();

    // Exit on an already free slot raises err without a valid event
    do_exit(3'd7);
    check_idle();
    do_exit(3'd7);
    check_idle();

    // Parking clock wrap with TICK_DIV = 3
    do_reset();
    pulse_ticks(768);
    do_entry();
    check_idle();
    pulse_ticks(2);
    do_entry();
    check_idle();

    // Reset while an event is being presented drops its commit
    do_entry();
    #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rstp_capacity", 32'(ifc.parking_capacity), 32'hFF);
    chk("rstp_ev_valid", 32'(ifc.ev_valid), 32'd0);
    chk("rstp_occupied", 32'(occupied), 32'd0);
    chk("rstp_exit_ready", 32'(ifc.exit_ready), 32'd0);
    rst = 1'b0;
    check_idle();

    // Randomized traffic with random ticks
    tick_rand = 1'b1;
    for (int k = 0; k < 200; k++) begin
      int         op;
      logic [2:0] s;
      op = $urandom_range(0, 2);
      s  = 3'($urandom_range(0, 7));
      if (op == 0 && mfree_cnt() > 0) do_entry();
      else if (op == 2 && mfree_cnt() > 0) do_both(s);
      else do_exit(s);
      check_idle();
    end
    tick_rand = 1'b0;

    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
